m_spi_slave: RTL and testbench

M_SPI_SLAVE -- requirements
Module: m_spi_slave

---
 rtl/m_spi_slave.sv | 130 +++++++++++++
 tb/tb_m_spi_slave.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/m_spi_slave.sv
// m_spi_slave: SPI mode-0 (MSB first, 8-bit) slave receiver; define SPI_SLAVE_MISO_EN to add the MISO transmit path
module m_spi_slave #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       SPI_SCLK,
   input  logic       SPI_MOSI,
   input  logic       SPI_CS,
`ifdef SPI_SLAVE_MISO_EN
   input  logic [7:0] data_tx,
   output logic       SPI_MISO,
`endif
   output logic [7:0] data_rec,
   output logic       rec_valid,
   output logic       frame_err,
   output logic       busy
);
   typedef enum logic [1:0] {IDLE = 2'b01, RECV = 2'b10} state_t;
   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
   logic                   sclk_dly_q, cs_dly_q;
   logic                   sclk_s, mosi_s, cs_s;
   logic                   sclk_rise, cs_rise, cs_fall;
   logic [2:0]             bit_cnt_q, bit_cnt_d;
   logic [7:0]             shift_q, shift_d, data_rec_q, data_rec_d;
   logic                   rec_valid_q, rec_valid_d, frame_err_q, frame_err_d;
   logic                   byte_done;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign cs_s      = cs_sync_q[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_dly_q;
   assign cs_rise   = cs_s & ~cs_dly_q;
   assign cs_fall   = ~cs_s & cs_dly_q;

   // Identical-depth synchronisers keep SCLK/MOSI/CS aligned; CS idles high so reset cannot fake a falling edge
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sclk_sync_q <= '0;
         mosi_sync_q <= '0;
         cs_sync_q   <= '1;
         sclk_dly_q  <= 1'b0;
         cs_dly_q    <= 1'b1;
      end else begin
         sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], SPI_SCLK};
         mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
         cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], SPI_CS};
         sclk_dly_q  <= sclk_s;
         cs_dly_q    <= cs_s;
      end
   end

   // State and receive datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         data_rec_q  <= '0;
         rec_valid_q <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         data_rec_q  <= data_rec_d;
         rec_valid_q <= rec_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Next state: shift on SCLK rise, complete byte on 8th bit, flag a partial byte when CS rises
   always_comb begin
      state_d     = state_q;
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      data_rec_d  = data_rec_q;
      rec_valid_d = 1'b0;
      frame_err_d = 1'b0;
      byte_done   = 1'b0;
      case (state_q)
         IDLE: begin
            if (cs_fall) begin
               state_d   = RECV;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         RECV: begin
            if (sclk_rise) begin
               shift_d   = {shift_q[6:0], mosi_s};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  byte_done   = 1'b1;
                  data_rec_d  = shift_d;
                  rec_valid_d = 1'b1;
               end
            end
            if (cs_rise) begin
               state_d     = IDLE;
               frame_err_d = (bit_cnt_d != 3'd0);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign data_rec  = data_rec_q;
   assign rec_valid = rec_valid_q;
   assign frame_err = frame_err_q;
   assign busy      = (state_q == RECV);

`ifdef SPI_SLAVE_MISO_EN
   logic       sclk_fall;
   logic [7:0] tx_q;
   assign sclk_fall = ~sclk_s & sclk_dly_q;
   assign SPI_MISO  = busy & tx_q[7];

   // Transmit shifter: reload at frame start and each byte end, advance on SCLK fall
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tx_q <= '0;
      else if ((state_q == IDLE && cs_fall) || byte_done)
         tx_q <= data_tx;
      else if (state_q == RECV && sclk_fall)
         tx_q <= {tx_q[6:0], 1'b0};
   end
`endif
endmodule

// File: tb/tb_m_spi_slave.sv
// tb_m_spi_slave: scoreboard bench for m_spi_slave (MISO checks when SPI_SLAVE_MISO_EN is defined)
module tb_m_spi_slave;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       cs = 1'b1;
   logic [7:0] data_rec;
   logic       rec_valid, frame_err, busy;
`ifdef SPI_SLAVE_MISO_EN
   logic [7:0] data_tx = 8'h00;
   logic       miso;
`endif
   logic [7:0] miso_bits = 8'h00;

   typedef struct packed {logic err; logic [7:0] d;} ev_t;
   ev_t        exp_q[$];
   int         checks = 0;
   int         fails = 0;
   logic [7:0] last = 8'h00;

   always #5 clk = ~clk;

   m_spi_slave #(.SYNC_STAGES(2)) dut (
      .clk(clk),
      .reset(reset),
      .SPI_SCLK(sclk),
      .SPI_MOSI(mosi),
      .SPI_CS(cs),
`ifdef SPI_SLAVE_MISO_EN
      .data_tx(data_tx),
      .SPI_MISO(miso),
`endif
      .data_rec(data_rec),
      .rec_valid(rec_valid),
      .frame_err(frame_err),
      .busy(busy)
   );

   // Monitor: every output event must match the head of the expected queue
   always @(negedge clk) begin
      if (rec_valid || frame_err) begin
         checks++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_event: rec_valid=%b frame_err=%b data_rec=%h, none expected", rec_valid, frame_err, data_rec);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (rec_valid !== !e.err || frame_err !== e.err || data_rec !== e.d) begin
               fails++;
               $display("FAIL event: got rec_valid=%b frame_err=%b data_rec=%h, want rec_valid=%b frame_err=%b data_rec=%h",
                        rec_valid, frame_err, data_rec, !e.err, e.err, e.d);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_byte(input logic [7:0] b);
      exp_q.push_back({1'b0, b});
      last = b;
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, input int half);
      for (int i = 7; i > 7 - n; i--) begin
         sclk = 1'b0;
         mosi = b[i];
         clks(half);
         sclk = 1'b1;
`ifdef SPI_SLAVE_MISO_EN
         miso_bits = {miso_bits[6:0], miso};
`endif
         clks(half);
      end
      sclk = 1'b0;
   endtask

   task automatic cs_low();
      cs = 1'b0;
      clks(8);
      check("busy_in_frame", busy, 1);
   endtask

   task automatic cs_high(input string name);
      clks(4);
      cs = 1'b1;
      clks(8);
      check({"busy_after_", name}, busy, 0);
      check({"queue_empty_", name}, exp_q.size(), 0);
   endtask

   initial begin
      clks(3);
      check("reset_data_rec", data_rec, 8'h00);
      check("reset_rec_valid", rec_valid, 0);
      check("reset_frame_err", frame_err, 0);
      check("reset_busy", busy, 0);
      reset = 1'b0;
      clks(4);
      check("idle_busy", busy, 0);

      cs_low();
      expect_byte(8'hA5);
      send_bits(8'hA5, 8, 2);
      cs_high("a5");
      check("hold_a5", data_rec, 8'hA5);

      cs_low();
      expect_byte(8'h3C);
      expect_byte(8'hFF);
      expect_byte(8'h00);
      send_bits(8'h3C, 8, 2);
      send_bits(8'hFF, 8, 2);
      send_bits(8'h00, 8, 2);
      cs_high("multi");
      check("hold_00", data_rec, 8'h00);

      expect_byte(8'h77);
      cs_low();
      send_bits(8'h77, 8, 2);
      cs_high("77");

      cs_low();
      exp_q.push_back({1'b1, last});
      send_bits(8'h81, 5, 2);
      cs_high("frame_err");
      check("hold_after_err", data_rec, 8'h77);

      cs_low();
      send_bits(8'h5A, 4, 2);
      reset = 1'b1;
      clks(2);
      check("midreset_data_rec", data_rec, 8'h00);
      check("midreset_busy", busy, 0);
      check("midreset_rec_valid", rec_valid, 0);
      check("midreset_frame_err", frame_err, 0);
      cs = 1'b1;
      sclk = 1'b0;
      clks(4);
      reset = 1'b0;
      last = 8'h00;
      clks(6);
      check("post_reset_idle", busy, 0);
      cs_low();
      expect_byte(8'h5A);
      send_bits(8'h5A, 8, 2);
      cs_high("5a");

      for (int i = 0; i < 16; i++) begin
         mosi = i[0];
         sclk = ~sclk;
         clks(3);
         if (i % 4 == 3) check("cs_high_busy", busy, 0);
      end
      sclk = 1'b0;
      clks(8);
      check("cs_high_queue", exp_q.size(), 0);
      check("cs_high_hold", data_rec, 8'h5A);

`ifdef SPI_SLAVE_MISO_EN
      data_tx = 8'hC3;
      cs_low();
      expect_byte(8'h12);
      send_bits(8'h12, 8, 6);
      cs_high("miso");
      check("miso_bits", miso_bits, 8'hC3);
      check("miso_idle", miso, 0);
`endif

      clks(4);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
